// File: rtl/logic_nentries_filtered_gate_if.sv
// logic_nentries_filtered_gate_if: control, raw input and result bundle of the filtered gate
interface logic_nentries_filtered_gate_if #(
    parameter int N_INPUTS = 3,
    parameter int CNT_W    = 16
);
    logic                en;
    logic [1:0]          mode;
    logic [N_INPUTS-1:0] in_bits;
    logic                cnt_clr;
    logic                z;
    logic                z_valid;
    logic                z_rise;
    logic                z_fall;
    logic [CNT_W-1:0]    toggle_cnt;
    modport master (output en, mode, in_bits, cnt_clr, input z, z_valid, z_rise, z_fall, toggle_cnt);
    modport slave  (input en, mode, in_bits, cnt_clr, output z, z_valid, z_rise, z_fall, toggle_cnt);
endinterface

// File: rtl/logic_nentries_filtered_gate.sv
// logic_nentries_filtered_gate: synchronised, glitch-filtered N-input AND/OR/XOR/NAND with edge reporting
module logic_nentries_filtered_gate #(
    parameter int N_INPUTS      = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input logic clk,
    input logic rst,
    logic_nentries_filtered_gate_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    logic [1:0]          r_state;
    logic [CW-1:0]       r_sc;
    logic [N_INPUTS-1:0] r_s1;
    logic [N_INPUTS-1:0] r_s2;
    logic [N_INPUTS-1:0] r_filt;
    logic [N_INPUTS-1:0] w_flip;
    logic                r_z;
    logic                r_rise;
    logic                r_fall;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_run;
    logic                w_settle;
    logic                w_z_next;
    assign w_run    = bus.en && r_state == S_RUN;
    assign w_settle = bus.en && r_state == S_SETTLE;
    // gate function over the filtered bits
    always_comb begin
        w_z_next = bus.mode == 2'b00 ? &r_filt :
                   bus.mode == 2'b01 ? |r_filt :
                   bus.mode == 2'b10 ? ^r_filt : ~&r_filt;
    end
    // sequencing: any edge with en low returns to IDLE and discards the settle count
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            r_state <= S_IDLE;
            r_sc    <= '0;
        end else if (r_state == S_IDLE) begin
            r_state <= S_SETTLE;
            r_sc    <= '0;
        end else if (r_state == S_SETTLE) begin
            r_state <= r_sc == CW'(STABLE_CYCLES - 1) ? S_RUN : S_SETTLE;
            r_sc    <= r_sc + 1'b1;
        end
    end
    // two-flop synchroniser on every raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.in_bits;
            r_s2 <= r_s1;
        end
    end
    genvar g;
    generate
        for (g = 0; g < N_INPUTS; g++) begin : g_filt
            logic [CW-1:0] r_fc;
            logic          w_mis;
            assign w_mis     = r_s2[g] ^ r_filt[g];
            assign w_flip[g] = w_mis && r_fc == CW'(STABLE_CYCLES - 1);
            // mismatch run length; only counts in RUN so a re-enable starts from scratch
            always_ff @(posedge clk) begin
                if (rst || !w_run)
                    r_fc <= '0;
                else
                    r_fc <= (w_mis && !w_flip[g]) ? r_fc + 1'b1 : '0;
            end
        end
    endgenerate
    // filtered bits: copied straight through while settling, debounced while running
    always_ff @(posedge clk) begin
        if (rst)
            r_filt <= '0;
        else
            r_filt <= w_settle ? r_s2 : w_run ? r_filt ^ w_flip : r_filt;
    end
    // registered result plus edge pulses, pulses only for changes seen in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_z    <= (w_settle || w_run) ? w_z_next : r_z;
            r_rise <= w_run && w_z_next && !r_z;
            r_fall <= w_run && !w_z_next && r_z;
        end
    end
    // saturating edge counter; clear beats a simultaneous edge
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr)
            r_cnt <= '0;
        else if (w_run && (w_z_next ^ r_z) && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end
    assign bus.z          = r_z;
    assign bus.z_valid    = r_state == S_RUN;
    assign bus.z_rise     = r_rise;
    assign bus.z_fall     = r_fall;
    assign bus.toggle_cnt = r_cnt;
endmodule

// File: tb/tb_logic_nentries_filtered_gate.sv
// tb_logic_nentries_filtered_gate: directed check of reset, settle, filtering, modes and counters
module tb_logic_nentries_filtered_gate;
    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    logic_nentries_filtered_gate_if #(.N_INPUTS(3), .CNT_W(16)) u_if1 ();
    logic_nentries_filtered_gate_if #(.N_INPUTS(3), .CNT_W(2))  u_if2 ();
    assign u_if2.en      = u_if1.en;
    assign u_if2.mode    = u_if1.mode;
    assign u_if2.in_bits = u_if1.in_bits;
    assign u_if2.cnt_clr = u_if1.cnt_clr;
    logic_nentries_filtered_gate #(.N_INPUTS(3), .STABLE_CYCLES(4), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .bus(u_if1)
    );
    logic_nentries_filtered_gate #(.N_INPUTS(3), .STABLE_CYCLES(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(u_if2)
    );
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        rst = 1'b1;
        u_if1.en = 1'b0;
        u_if1.mode = 2'b00;
        u_if1.in_bits = 3'b111;
        u_if1.cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_z", u_if1.z, 0);
            chk("rst_valid", u_if1.z_valid, 0);
            chk("rst_cnt", u_if1.toggle_cnt, 0);
        end
        rst = 1'b0;
        u_if1.en = 1'b1;
        tick(1);
        chk("rst_after_z", u_if1.z, 0);
        tick(3);
        chk("settle_valid_lo", u_if1.z_valid, 0);
        chk("settle_no_rise", u_if1.z_rise, 0);
        tick(1);
        chk("run_valid", u_if1.z_valid, 1);
        chk("run_z_and", u_if1.z, 1);
        chk("run_no_rise", u_if1.z_rise, 0);
        tick(1);
        chk("run_hold_z", u_if1.z, 1);
        chk("run_cnt0", u_if1.toggle_cnt, 0);
        u_if1.in_bits = 3'b011;
        tick(6);
        chk("lat_z_before", u_if1.z, 1);
        chk("lat_fall_before", u_if1.z_fall, 0);
        tick(1);
        chk("lat_z_fell", u_if1.z, 0);
        chk("lat_fall", u_if1.z_fall, 1);
        chk("lat_cnt1", u_if1.toggle_cnt, 1);
        tick(1);
        chk("fall_one_cycle", u_if1.z_fall, 0);
        u_if1.in_bits = 3'b111;
        tick(3);
        u_if1.in_bits = 3'b011;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_z", u_if1.z, 0);
            chk("glitch_rise", u_if1.z_rise, 0);
        end
        chk("glitch_cnt", u_if1.toggle_cnt, 1);
        u_if1.mode = 2'b10;
        tick(2);
        chk("xor_z", u_if1.z, 0);
        chk("xor_no_rise", u_if1.z_rise, 0);
        chk("xor_cnt", u_if1.toggle_cnt, 1);
        u_if1.mode = 2'b01;
        tick(1);
        chk("or_z", u_if1.z, 1);
        chk("or_rise", u_if1.z_rise, 1);
        chk("or_no_fall", u_if1.z_fall, 0);
        chk("or_cnt", u_if1.toggle_cnt, 2);
        tick(1);
        chk("rise_one_cycle", u_if1.z_rise, 0);
        u_if1.mode = 2'b11;
        tick(1);
        chk("nand_z", u_if1.z, 1);
        chk("nand_cnt", u_if1.toggle_cnt, 2);
        u_if1.mode = 2'b00;
        tick(1);
        chk("and_fall", u_if1.z_fall, 1);
        chk("cnt3", u_if1.toggle_cnt, 3);
        chk("sat_cnt3", u_if2.toggle_cnt, 3);
        u_if1.mode = 2'b01;
        tick(1);
        u_if1.mode = 2'b00;
        tick(1);
        chk("cnt5", u_if1.toggle_cnt, 5);
        chk("sat_hold", u_if2.toggle_cnt, 3);
        u_if1.mode = 2'b01;
        u_if1.cnt_clr = 1'b1;
        tick(1);
        chk("clr_rise", u_if1.z_rise, 1);
        chk("clr_wins", u_if1.toggle_cnt, 0);
        chk("clr_wins_sat", u_if2.toggle_cnt, 0);
        u_if1.cnt_clr = 1'b0;
        u_if1.mode = 2'b00;
        tick(1);
        chk("post_clr_cnt", u_if1.toggle_cnt, 1);
        u_if1.in_bits = 3'b111;
        tick(4);
        u_if1.en = 1'b0;
        tick(1);
        chk("idle_valid", u_if1.z_valid, 0);
        chk("idle_z", u_if1.z, 0);
        tick(3);
        chk("idle_hold_z", u_if1.z, 0);
        chk("idle_no_rise", u_if1.z_rise, 0);
        u_if1.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("reen_valid_lo", u_if1.z_valid, 0);
            chk("reen_no_rise", u_if1.z_rise, 0);
        end
        tick(1);
        chk("reen_valid", u_if1.z_valid, 1);
        chk("reen_z", u_if1.z, 1);
        chk("reen_no_pulse", u_if1.z_rise, 0);
        chk("reen_cnt", u_if1.toggle_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
